slink_crc_append_seq: RTL
=========================

// Module: slink_crc_append_seq
// PURPOSE
//  Sequences the 8-bit/16-bit CRC engine (slink_crc_8_16bit_compute) over a byte-wide packet stream.
//  Forwards payload bytes unchanged, then appends the 16-bit CRC-16/MCRF4XX as two trailing bytes, LSB first.
//  Sits in the S-Link TX packet path between the packet builder and the lane distributor.
// PARAMETERS
//  CNT_W    16       width of pkt_count (wraps) and byte_count (saturates)
//  CRC_INIT 16'hFFFF CRC seed loaded at every accepted SOP byte
// PORTS
//  clk         in   1      clock
//  reset       in   1      asynchronous, active-high reset
//  enable      in   1      allows a new packet to start; sampled only in IDLE
//  s_valid     in   1      upstream byte valid
//  s_ready     out  1      upstream byte accepted when s_valid & s_ready
//  s_data      in   8      upstream payload byte
//  s_sop       in   1      first byte of packet
//  s_eop       in   1      last payload byte of packet
//  m_valid     out  1      downstream byte valid
//  m_ready     in   1      downstream ready
//  m_data      out  8      payload byte or CRC byte
//  m_sop       out  1      first byte of the output packet
//  m_eop       out  1      last byte of the output packet, i.e. the CRC high byte
//  crc_out     out  16     final CRC of the last completed packet
//  crc_done    out  1      1-cycle pulse when the CRC high byte is accepted
//  pkt_count   out  CNT_W  number of completed packets; wraps at 2^CNT_W
//  byte_count  out  CNT_W  payload bytes of the current/last packet; saturates at all-ones
//  proto_err   out  1      1-cycle pulse on a framing violation
//  err_inj     in   1      only present with SLINK_CRC_SEQ_ERR_INJ_EN
// BEHAVIOUR
//  Reset values: state IDLE, crc reg=CRC_INIT, crc_out=0, pkt_count=0, byte_count=0, crc_done=0, proto_err=0.
//  While reset is high, s_ready=0 and m_valid=0.
//  FSM IDLE -> PAYLOAD -> CRC_LO -> CRC_HI -> IDLE.
//  Payload is a combinational pass-through with 0-cycle latency:
//   - m_data=s_data, m_valid=s_valid, s_ready=m_ready (gated as listed below).
//  IDLE: s_ready = m_ready & enable.
//   - Accepted byte with s_sop=1: forwarded with m_sop=1; crc <= f(CRC_INIT, s_data); byte_count <= 1.
//   - Next state: CRC_LO if s_eop=1, else PAYLOAD.
//   - Accepted byte with s_sop=0: dropped (m_valid=0); proto_err pulses.
//   - enable=0: s_ready=0 and m_valid=0.
//  PAYLOAD: s_ready=m_ready. Each accepted byte does crc <= f(crc, s_data) and increments byte_count.
//   - s_sop=1 in PAYLOAD: byte treated as payload; m_sop=0; proto_err pulses.
//   - Accepted byte with s_eop=1: forwarded with m_eop=0; next state CRC_LO.
//  CRC_LO: s_ready=0; m_valid=1; m_data=crc[7:0]. On m_ready -> CRC_HI.
//  CRC_HI: s_ready=0; m_valid=1; m_data=crc[15:8]; m_eop=1. On m_ready:
//   - crc_out <= crc; crc_done pulses; pkt_count++; next state IDLE.
//  CRC update uses the engine's crc_in8 path (crc_prev=crc reg). The engine's init/valid are driven by this FSM.
//  Backpressure (m_ready=0) holds state, crc and m_data stable; no byte is lost or duplicated.
//  enable deassertion mid-packet has no effect until the packet returns to IDLE.
//  Reset mid-packet: immediate return to IDLE. The partial packet is abandoned with no CRC emitted.
//  m_sop/m_eop are 0 whenever m_valid=0.
// CONFIGURATION
//  SLINK_CRC_SEQ_ERR_INJ_EN defined:
//   - err_inj port exists; it is sampled on the accepted SOP byte.
//   - If err_inj was set, both appended CRC bytes and crc_out are XORed with 16'h0001.
//  Not defined: port absent; CRC is always correct.
// TESTING
//  1. 24-byte packet FF 00 00 00 1E F0 1E C7 4F 82 78 C5 82 E0 8C 70 D2 3C 78 E9 FF 00 00 01, sop on byte 0, eop on byte 23
//     -> 26 output beats, last two 0x69, 0xE5 (m_eop on 0xE5); crc_out=0xE569; crc_done 1 cycle; pkt_count=1; byte_count=24.
//  2. Single byte 0x00 with sop&eop -> output 0x00(sop), 0x87, 0x0F(eop); crc_out=0x0F87.
//  3. Test 1 with m_ready random 50% duty and s_valid gaps -> identical 26-byte output; crc_out=0xE569.
//  4. reset pulsed after 5 payload bytes, then test 2 -> m_valid=0 during reset; crc_out=0x0F87; pkt_count=1.
//  5. Non-SOP byte in IDLE -> not forwarded, proto_err=1 for 1 cycle. SOP mid-packet -> proto_err pulse, byte forwarded, m_sop=0.
//  6. With SLINK_CRC_SEQ_ERR_INJ_EN: test 1 with err_inj=1 at SOP -> CRC bytes 0x68, 0xE5; crc_out=0xE568.

Source files
------------

// File: rtl/slink_crc_append_seq.sv
// S-Link TX CRC appender: forwards payload bytes and appends CRC-16/MCRF4XX, LSB first.
// Optional CRC error injection is compiled in with `define SLINK_CRC_SEQ_ERR_INJ_EN.
module slink_crc_append_seq #(
   parameter int unsigned CNT_W    = 16,
   parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [7:0]       s_data,
   input  logic             s_sop,
   input  logic             s_eop,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [7:0]       m_data,
   output logic             m_sop,
   output logic             m_eop,
   output logic [15:0]      crc_out,
   output logic             crc_done,
   output logic [CNT_W-1:0] pkt_count,
   output logic [CNT_W-1:0] byte_count,
`ifdef SLINK_CRC_SEQ_ERR_INJ_EN
   input  logic             err_inj,
`endif
   output logic             proto_err
);

   typedef enum logic [1:0] {StIdle, StPayload, StCrcLo, StCrcHi} state_e;

   state_e      state_q;
   logic [15:0] crc_q;
   logic        inj_q;
   logic        inj_in;
   logic        s_fire;
   logic [15:0] crc_prev;
   logic [15:0] crc_next;

`ifdef SLINK_CRC_SEQ_ERR_INJ_EN
   assign inj_in = err_inj;
`else
   assign inj_in = 1'b0;
`endif

   // Byte-wise reflected CRC-16 (poly 0x8408), the engine's crc_in8 path.
   function automatic logic [15:0] crc_in8(input logic [15:0] prev, input logic [7:0] data);
      logic [15:0] c;
      c = prev ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      end
      return c;
   endfunction

   assign s_fire   = s_valid & s_ready;
   assign crc_prev = (state_q == StIdle) ? CRC_INIT : crc_q;
   assign crc_next = crc_in8(crc_prev, s_data);

   always_comb begin
      s_ready = 1'b0;
      m_valid = 1'b0;
      m_data  = s_data;
      m_sop   = 1'b0;
      m_eop   = 1'b0;
      if (!reset) begin
         unique case (state_q)
            StIdle: begin
               s_ready = m_ready & enable;
               // Non-SOP bytes in IDLE are swallowed, never presented downstream.
               m_valid = s_valid & enable & s_sop;
               m_sop   = s_valid & enable & s_sop;
            end
            StPayload: begin
               s_ready = m_ready;
               m_valid = s_valid;
            end
            StCrcLo: begin
               m_valid = 1'b1;
               m_data  = crc_q[7:0] ^ {7'b0, inj_q};
            end
            StCrcHi: begin
               m_valid = 1'b1;
               m_data  = crc_q[15:8];
               m_eop   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         crc_q      <= CRC_INIT;
         inj_q      <= 1'b0;
         crc_out    <= 16'h0000;
         crc_done   <= 1'b0;
         proto_err  <= 1'b0;
         pkt_count  <= '0;
         byte_count <= '0;
      end else begin
         crc_done  <= 1'b0;
         proto_err <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (s_fire) begin
                  if (s_sop) begin
                     crc_q      <= crc_next;
                     inj_q      <= inj_in;
                     byte_count <= CNT_W'(1);
                     state_q    <= s_eop ? StCrcLo : StPayload;
                  end else begin
                     proto_err <= 1'b1;
                  end
               end
            end
            StPayload: begin
               if (s_fire) begin
                  crc_q <= crc_next;
                  if (byte_count != {CNT_W{1'b1}}) begin
                     byte_count <= byte_count + CNT_W'(1);
                  end
                  if (s_sop) begin
                     proto_err <= 1'b1;
                  end
                  if (s_eop) begin
                     state_q <= StCrcLo;
                  end
               end
            end
            StCrcLo: begin
               if (m_ready) begin
                  state_q <= StCrcHi;
               end
            end
            StCrcHi: begin
               if (m_ready) begin
                  crc_out   <= crc_q ^ {15'b0, inj_q};
                  crc_done  <= 1'b1;
                  pkt_count <= pkt_count + CNT_W'(1);
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
